decode_stage_s: RTL and testbench

//  RV32I instruction-decode stage; sits between IF/ID and EX. Drives rs1/rs2 to the

---
 rtl/decode_stage_s.sv | 263 ++++++++++++++++++++++++++
 tb/tb_decode_stage_s.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_s.sv
// ---------------------------------------------------------------------------
// decode_stage_s
//   RV32I instruction-decode stage between IF/ID and EX.
//   Decodes the instruction word and drives the register-file read addresses
//   combinationally. Operands, the sign-extended immediate and the control bits
//   are captured into a single ID/EX slot with a valid/ready handshake. A
//   load-use hazard inserts one bubble; flush kills the slot.
//
//   Optional feature macro: FORWARD_WB_EN
//     When defined, a same-cycle write-back to rs1/rs2 is bypassed into the
//     captured operand, so the register file may write and be read on the
//     same edge. When undefined, operands come straight from the register
//     file and a 1-cycle write-to-read gap is assumed.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   flush                      taken branch/jump in EX, kill the ID/EX slot
//   inValid / inReady          IF/ID handshake (instr, pc)
//   rs1, rs2                   register-file read addresses
//   readData1, readData2       register-file read data
//   wbWrite, wbRd, wbData      write-back port (used for the optional bypass)
//   outValid / outReady        ID/EX handshake
//   exPc, exData1, exData2, exImm, exRd, exOpcode, exFunct3, exFunct7b5
//   exRegWrite, exMemRead, exMemWrite, exBranch, exJump, exIllegal
// ---------------------------------------------------------------------------
module decode_stage_s #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] rs1,
    output logic [ADDR_WIDTH-1:0] rs2,
    input  logic [DATA_WIDTH-1:0] readData1,
    input  logic [DATA_WIDTH-1:0] readData2,
    input  logic                  wbWrite,
    input  logic [ADDR_WIDTH-1:0] wbRd,
    input  logic [DATA_WIDTH-1:0] wbData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [DATA_WIDTH-1:0] exPc,
    output logic [DATA_WIDTH-1:0] exData1,
    output logic [DATA_WIDTH-1:0] exData2,
    output logic [DATA_WIDTH-1:0] exImm,
    output logic [ADDR_WIDTH-1:0] exRd,
    output logic [6:0]            exOpcode,
    output logic [2:0]            exFunct3,
    output logic                  exFunct7b5,
    output logic                  exRegWrite,
    output logic                  exMemRead,
    output logic                  exMemWrite,
    output logic                  exBranch,
    output logic                  exJump,
    output logic                  exIllegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] rd;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign rd     = ADDR_WIDTH'(instr[11:7]);
    assign rs1    = ADDR_WIDTH'(instr[19:15]);
    assign rs2    = ADDR_WIDTH'(instr[24:20]);

    // Raw immediates in each format, all sign-extended from instr[31].
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic        use_rs1;
    logic        use_rs2;
    logic        dec_reg_write;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_branch;
    logic        dec_jump;
    logic        dec_illegal;
    logic [31:0] dec_imm;

    always_comb begin
        use_rs1       = 1'b0;
        use_rs2       = 1'b0;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_branch    = 1'b0;
        dec_jump      = 1'b0;
        dec_illegal   = 1'b0;
        dec_imm       = 32'b0;
        case (opcode)
            OP_R: begin
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                dec_reg_write = 1'b1;
            end
            OP_I_ALU: begin
                use_rs1       = 1'b1;
                dec_reg_write = 1'b1;
                dec_imm       = imm_i;
            end
            OP_LOAD: begin
                use_rs1       = 1'b1;
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
                dec_imm       = imm_i;
            end
            OP_STORE: begin
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                dec_mem_write = 1'b1;
                dec_imm       = imm_s;
            end
            OP_BRANCH: begin
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                dec_branch    = 1'b1;
                dec_imm       = imm_b;
            end
            OP_LUI, OP_AUIPC: begin
                dec_reg_write = 1'b1;
                dec_imm       = imm_u;
            end
            OP_JAL: begin
                dec_reg_write = 1'b1;
                dec_jump      = 1'b1;
                dec_imm       = imm_j;
            end
            OP_JALR: begin
                use_rs1       = 1'b1;
                dec_reg_write = 1'b1;
                dec_jump      = 1'b1;
                dec_imm       = imm_i;
            end
            default: begin
                dec_illegal   = 1'b1;
            end
        endcase
    end

    // A write to x0 is dropped entirely, and a non-writing instruction
    // carries rd=0, so the hazard compare below never matches on x0.
    logic                  eff_reg_write;
    logic [ADDR_WIDTH-1:0] eff_rd;

    assign eff_reg_write = dec_reg_write & (rd != '0);
    assign eff_rd        = eff_reg_write ? rd : '0;

    // ------------------------------------------------------------------
    // Operand selection
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;

`ifdef FORWARD_WB_EN
    logic fwd1;
    logic fwd2;

    assign fwd1 = wbWrite & (wbRd != '0) & (wbRd == rs1);
    assign fwd2 = wbWrite & (wbRd != '0) & (wbRd == rs2);
    assign op1  = fwd1 ? wbData : readData1;
    assign op2  = fwd2 ? wbData : readData2;
`else
    logic unused_wb;

    assign unused_wb = ^{wbWrite, wbRd, wbData};
    assign op1       = readData1;
    assign op2       = readData2;
`endif

    // ------------------------------------------------------------------
    // Handshake and hazard
    // ------------------------------------------------------------------
    logic hazard;
    logic slot_free;
    logic accept;

    // The load in the slot produces its data only after MEM, so a
    // consumer decoded now must wait one cycle behind it.
    assign hazard = outValid & exMemRead & (exRd != '0) &
                    ((use_rs1 & (exRd == rs1)) | (use_rs2 & (exRd == rs2)));

    assign slot_free = ~outValid | outReady;
    assign inReady   = rst_n & slot_free & ~hazard & ~flush;
    assign accept    = inValid & inReady;

    // ------------------------------------------------------------------
    // ID/EX slot
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outValid   <= 1'b0;
            exPc       <= '0;
            exData1    <= '0;
            exData2    <= '0;
            exImm      <= '0;
            exRd       <= '0;
            exOpcode   <= '0;
            exFunct3   <= '0;
            exFunct7b5 <= 1'b0;
            exRegWrite <= 1'b0;
            exMemRead  <= 1'b0;
            exMemWrite <= 1'b0;
            exBranch   <= 1'b0;
            exJump     <= 1'b0;
            exIllegal  <= 1'b0;
        end else if (flush) begin
            outValid <= 1'b0;
        end else if (accept) begin
            outValid   <= 1'b1;
            exPc       <= pc;
            exData1    <= op1;
            exData2    <= op2;
            exImm      <= DATA_WIDTH'(signed'(dec_imm));
            exRd       <= eff_rd;
            exOpcode   <= opcode;
            exFunct3   <= funct3;
            exFunct7b5 <= instr[30];
            exRegWrite <= eff_reg_write;
            exMemRead  <= dec_mem_read;
            exMemWrite <= dec_mem_write;
            exBranch   <= dec_branch;
            exJump     <= dec_jump;
            exIllegal  <= dec_illegal;
        end else if (hazard && outReady) begin
            // Load leaves for EX; the consumer is taken next cycle.
            outValid <= 1'b0;
        end else if (outReady && !inValid) begin
            outValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage_s.sv
module tb_decode_stage_s;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic        wbWrite;
    logic [4:0]  wbRd;
    logic [31:0] wbData;
    logic        outValid;
    logic        outReady;
    logic [31:0] exPc;
    logic [31:0] exData1;
    logic [31:0] exData2;
    logic [31:0] exImm;
    logic [4:0]  exRd;
    logic [6:0]  exOpcode;
    logic [2:0]  exFunct3;
    logic        exFunct7b5;
    logic        exRegWrite;
    logic        exMemRead;
    logic        exMemWrite;
    logic        exBranch;
    logic        exJump;
    logic        exIllegal;

    decode_stage_s #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .inValid(inValid), .inReady(inReady), .instr(instr), .pc(pc),
        .rs1(rs1), .rs2(rs2), .readData1(readData1), .readData2(readData2),
        .wbWrite(wbWrite), .wbRd(wbRd), .wbData(wbData),
        .outValid(outValid), .outReady(outReady),
        .exPc(exPc), .exData1(exData1), .exData2(exData2), .exImm(exImm),
        .exRd(exRd), .exOpcode(exOpcode), .exFunct3(exFunct3),
        .exFunct7b5(exFunct7b5), .exRegWrite(exRegWrite),
        .exMemRead(exMemRead), .exMemWrite(exMemWrite),
        .exBranch(exBranch), .exJump(exJump), .exIllegal(exIllegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model, read combinationally.
    logic [31:0] rf [32];
    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 | (i * 32'h0001_0101);
        rf[0] = 32'h0;
        rf[3] = 32'h0;
    end
    assign readData1 = rf[rs1];
    assign readData2 = rf[rs2];

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [16:0] ctrl;
    } exp_t;

    exp_t sb [$];

    function automatic exp_t model(input logic [31:0] i, input logic [31:0] p,
                                   input logic [31:0] d1, input logic [31:0] d2);
        exp_t e;
        logic rw, mr, mw, br, jp, il;
        e.pc  = p;
        e.d1  = d1;
        e.d2  = d2;
        e.imm = 32'h0;
        rw = 0; mr = 0; mw = 0; br = 0; jp = 0; il = 0;
        case (i[6:0])
            7'h33: rw = 1;
            7'h13: begin rw = 1; e.imm = {{20{i[31]}}, i[31:20]}; end
            7'h03: begin rw = 1; mr = 1; e.imm = {{20{i[31]}}, i[31:20]}; end
            7'h23: begin mw = 1; e.imm = {{20{i[31]}}, i[31:25], i[11:7]}; end
            7'h63: begin br = 1; e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; end
            7'h37, 7'h17: begin rw = 1; e.imm = {i[31:12], 12'h000}; end
            7'h6F: begin rw = 1; jp = 1; e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; end
            7'h67: begin rw = 1; jp = 1; e.imm = {{20{i[31]}}, i[31:20]}; end
            default: il = 1;
        endcase
        if (i[11:7] == 5'd0) rw = 0;
        e.rd   = rw ? i[11:7] : 5'd0;
        e.ctrl = {i[6:0], i[14:12], i[30], rw, mr, mw, br, jp, il};
        return e;
    endfunction

    // Scoreboard: push on acceptance, pop on consumption, drop on flush.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] d1, d2;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (outValid && flush) begin
                if (sb.size() > 0) void'(sb.pop_front());
            end else if (outValid && outReady) begin
                if (sb.size() == 0) begin
                    check_val("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check_val("sb_pc",    exPc,    e.pc);
                    check_val("sb_data1", exData1, e.d1);
                    check_val("sb_data2", exData2, e.d2);
                    check_val("sb_imm",   exImm,   e.imm);
                    check_val("sb_rd",    32'(exRd), 32'(e.rd));
                    check_val("sb_ctrl",
                              32'({exOpcode, exFunct3, exFunct7b5, exRegWrite, exMemRead,
                                   exMemWrite, exBranch, exJump, exIllegal}),
                              32'(e.ctrl));
                end
            end
            if (inValid && inReady) begin
                d1 = rf[instr[19:15]];
                d2 = rf[instr[24:20]];
`ifdef FORWARD_WB_EN
                if (wbWrite && wbRd != 5'd0 && wbRd == instr[19:15]) d1 = wbData;
                if (wbWrite && wbRd != 5'd0 && wbRd == instr[24:20]) d2 = wbData;
`endif
                sb.push_back(model(instr, pc, d1, d2));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after acceptance.
    task automatic send(input logic [31:0] i, input logic [31:0] p);
        int n;
        n = 0;
        inValid = 1'b1;
        instr   = i;
        pc      = p;
        @(negedge clk);
        while (!inReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!inReady) check_val("accept_timeout", 32'(inReady), 32'd1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    localparam logic [31:0] ADDI_M3 = 32'hFFD0_0293; // addi x5,x0,-3
    localparam logic [31:0] LW_X6   = 32'h0000_A303; // lw   x6,0(x1)
    localparam logic [31:0] ADD_X7  = 32'h0023_03B3; // add  x7,x6,x2
    localparam logic [31:0] ADDI_X9 = 32'h0060_8493; // addi x9,x1,6 (rs2 field = 6)
    localparam logic [31:0] ADDI_X8 = 32'h0010_0413; // addi x8,x0,1
    localparam logic [31:0] ADDI_X9B= 32'h0020_0493; // addi x9,x0,2
    localparam logic [31:0] ADD_X4  = 32'h0001_8233; // add  x4,x3,x0

    logic [6:0] ops [10];
    bit         rnd_done;

    initial begin
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};
        rst_n = 0; flush = 0; inValid = 0; instr = 0; pc = 0;
        outReady = 1; wbWrite = 0; wbRd = 0; wbData = 0;

        // Reset
        @(negedge clk);
        check_val("rst_inReady_low", 32'(inReady), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        check_val("rst_outValid",   32'(outValid),   32'd0);
        check_val("rst_exRegWrite", 32'(exRegWrite), 32'd0);
        check_val("rst_inReady",    32'(inReady),    32'd1);
        check_val("rst_exPc",       exPc,            32'd0);
        @(posedge clk); #1;

        // ADDI
        send(ADDI_M3, 32'h10);
        check_val("addi_valid", 32'(outValid),   32'd1);
        check_val("addi_rd",    32'(exRd),       32'd5);
        check_val("addi_imm",   exImm,           32'hFFFF_FFFD);
        check_val("addi_rw",    32'(exRegWrite), 32'd1);
        check_val("addi_pc",    exPc,            32'h10);
        @(posedge clk); #1;

        // Load-use bubble
        inValid = 1; instr = LW_X6; pc = 32'h20;
        @(negedge clk);
        check_val("lw_inReady", 32'(inReady), 32'd1);
        @(posedge clk); #1;
        instr = ADD_X7; pc = 32'h24;
        @(negedge clk);
        check_val("hz_inReady", 32'(inReady), 32'd0);
        check_val("hz_rs1",     32'(rs1),     32'd6);
        check_val("hz_rs2",     32'(rs2),     32'd2);
        @(posedge clk); #1;
        check_val("bubble_valid", 32'(outValid), 32'd0);
        @(negedge clk);
        check_val("after_bubble_inReady", 32'(inReady), 32'd1);
        @(posedge clk); #1;
        inValid = 0;
        check_val("add_valid", 32'(outValid), 32'd1);
        check_val("add_rd",    32'(exRd),     32'd7);
        check_val("add_pc",    exPc,          32'h24);

        // Unused rs2 field matching the load destination is not a hazard
        send(LW_X6, 32'h30);
        inValid = 1; instr = ADDI_X9; pc = 32'h34;
        @(negedge clk);
        check_val("no_false_hazard", 32'(inReady), 32'd1);
        @(posedge clk); #1;
        inValid = 0;
        check_val("nfh_pc", exPc, 32'h34);
        @(posedge clk); #1;

        // Back-pressure for 3 cycles
        send(ADDI_M3, 32'h40);
        outReady = 0; inValid = 1; instr = ADDI_X8; pc = 32'h44;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("stall_inReady", 32'(inReady),  32'd0);
            check_val("stall_valid",   32'(outValid), 32'd1);
            check_val("stall_pc",      exPc,          32'h40);
            check_val("stall_imm",     exImm,         32'hFFFF_FFFD);
            check_val("stall_rd",      32'(exRd),     32'd5);
        end
        @(posedge clk); #1;
        outReady = 1;
        @(negedge clk);
        check_val("resume_inReady0", 32'(inReady), 32'd1);
        @(posedge clk); #1;
        instr = ADDI_X9B; pc = 32'h48;
        @(negedge clk);
        check_val("resume_inReady1", 32'(inReady), 32'd1);
        check_val("resume_pc0",      exPc,         32'h44);
        @(posedge clk); #1;
        inValid = 0;
        check_val("resume_pc1",    exPc,          32'h48);
        check_val("resume_valid1", 32'(outValid), 32'd1);
        @(posedge clk); #1;

        // Flush
        send(ADDI_M3, 32'h80);
        inValid = 1; instr = ADDI_X8; pc = 32'h84; flush = 1;
        @(negedge clk);
        check_val("flush_inReady", 32'(inReady), 32'd0);
        @(posedge clk); #1;
        flush = 0; inValid = 0;
        check_val("flush_valid", 32'(outValid), 32'd0);
        check_val("flush_hold_pc", exPc, 32'h80);
        @(posedge clk); #1;

        // Write-back bypass
        wbWrite = 1; wbRd = 5'd3; wbData = 32'hCAFE_0001;
        send(ADD_X4, 32'h100);
        wbWrite = 0;
`ifdef FORWARD_WB_EN
        check_val("fwd_data1", exData1, 32'hCAFE_0001);
`else
        check_val("fwd_data1", exData1, 32'h0);
`endif
        check_val("fwd_rd", 32'(exRd), 32'd4);

        // Illegal opcode
        send(32'hFFFF_FFFF, 32'h104);
        check_val("ill_flag", 32'(exIllegal),  32'd1);
        check_val("ill_rw",   32'(exRegWrite), 32'd0);
        check_val("ill_rd",   32'(exRd),       32'd0);
        check_val("ill_jump", 32'(exJump),     32'd0);
        @(posedge clk); #1;

        // Random traffic with random back-pressure
        rnd_done = 0;
        fork
            begin
                for (int n = 0; n < 80; n++) begin
                    logic [31:0] r;
                    r = $urandom;
                    r[6:0] = ops[$urandom_range(0, 9)];
                    send(r, 32'h1000 + 32'(n) * 4);
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    outReady = ($urandom_range(0, 3) != 0);
                end
            end
        join
        outReady = 1;
        repeat (3) @(posedge clk);
        #1;
        check_val("sb_empty", 32'(sb.size()), 32'd0);

        // Reset mid-operation discards the slot
        outReady = 0;
        send(ADDI_X8, 32'h200);
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        check_val("midrst_valid", 32'(outValid), 32'd0);
        check_val("midrst_pc",    exPc,          32'h0);
        outReady = 1;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
